uart_tx_fifo: RTL and testbench

//  Downstream consumer of the memory-mapped UART TX byte port: CPU byte stores (wr_en/wr_data) are queued
//  in an internal circular FIFO and serialized 8N1 (LSB first) on tx.
//  It replaces the bare serializer behind the TX byte buffer and adds flow-control status (full/empty/level/overflow)

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_tx_fifo.sv | 141 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame constants and baud divisor helper
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_t;

  // Clock cycles per bit; integer divide, caller must keep the result >= 4.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter, ticks on the last cycle of every DIV-cycle bit
module uart_baud_tick #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // Count 0..DIV-1; restart pins the count at 0 so the next bit starts aligned.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 serializer; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 27_000_000,
  parameter int BAUD   = 115200,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  output logic          tx,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int DEPTH = 1 << AW;

  logic [7:0]                mem [0:DEPTH-1];
  logic [AW-1:0]             rd_ptr;
  logic [AW-1:0]             wr_ptr;
  uart_state_t               state;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [2:0]                bit_idx;
  logic                      par;
  logic                      tick;
  logic                      push;
  logic                      pop;

  // full is taken before any same-cycle pop, so a push at full is always dropped.
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign push  = wr_en && !full;
  assign pop   = (state == IDLE) && !empty;
  assign busy  = (state != IDLE);

  uart_baud_tick #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (state == IDLE),
    .tick    (tick)
  );

  // Byte storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Write pointer, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Frame FSM; tx registers the current state's line level, so it trails state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      rd_ptr  <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      par     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg  <= mem[rd_ptr];
            par    <= ^mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
            state  <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (tick) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          tx <= shreg[0];
          if (tick) begin
            shreg   <= {1'b0, shreg[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
        PARITY: begin
          tx <= par;
          if (tick) begin
            state <= STOP;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (tick) begin
            state <= IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo (honours UART_TX_PARITY_EN)
module tb_uart_tx_fifo;

  localparam int DIV   = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int FCYC = FRAME * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        clr_ovf = 1'b0;
  logic        tx;
  logic        busy;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue plus remaining busy cycles of the frame on the wire.
  logic [7:0] mq[$];
  int         busy_cnt = 0;
  logic [7:0] cur = '0;
  bit         m_ovf = 1'b0;
  bit         m_tx = 1'b1;

  function automatic bit frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (FRAME == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic model_step(input bit r, input bit w, input logic [7:0] d, input bit c);
    int sz;
    int bc;
    if (r) begin
      mq.delete();
      busy_cnt = 0;
      m_ovf = 1'b0;
      m_tx = 1'b1;
      return;
    end
    sz = mq.size();
    bc = busy_cnt;
    m_tx = (bc == 0) ? 1'b1 : frame_bit(cur, (FCYC - bc) / DIV);
    if (w) begin
      if (sz == DEPTH) m_ovf = 1'b1;
      else mq.push_back(d);
    end
    if (c && !(w && sz == DEPTH)) m_ovf = 1'b0;
    if (bc == 0) begin
      if (sz > 0) begin
        cur = mq.pop_front();
        busy_cnt = FCYC;
      end
    end else begin
      busy_cnt = bc - 1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit r, input bit w, input logic [7:0] d, input bit c);
    reset = r;
    wr_en = w;
    wr_data = d;
    clr_ovf = c;
    @(posedge clk);
    model_step(r, w, d, c);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    clr_ovf = 1'b0;
    chk("model_tx", int'(tx), int'(m_tx));
    chk("model_busy", int'(busy), int'(busy_cnt > 0));
    chk("model_level", int'(level), mq.size());
    chk("model_full", int'(full), int'(mq.size() == DEPTH));
    chk("model_empty", int'(empty), int'(mq.size() == 0));
    chk("model_overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    bit         rst;
    bit         we;
    logic [7:0] d;
    bit         clr;
    int         lvl;
    bit         e_full;
    bit         e_empty;
    bit         e_ovf;
    bit         e_busy;
    bit         e_tx;
  } vec_t;

  vec_t vt[7];
  bit   txs[0:399];

  initial begin
    int n;
    int peak;
    int lows;
    int b;

    // Reset, push into empty block, two-cycle latency to the falling start edge.
    vt[0] = '{1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1};
    vt[1] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1};
    vt[2] = '{0, 1, 8'h55, 0, 1, 0, 0, 0, 0, 1};
    vt[3] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 1};
    vt[4] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0};
    vt[5] = '{0, 1, 8'hAA, 0, 1, 0, 0, 0, 1, 0};
    vt[6] = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      tick(vt[i].rst, vt[i].we, vt[i].d, vt[i].clr);
      chk("vec_level", int'(level), vt[i].lvl);
      chk("vec_full", int'(full), int'(vt[i].e_full));
      chk("vec_empty", int'(empty), int'(vt[i].e_empty));
      chk("vec_overflow", int'(overflow), int'(vt[i].e_ovf));
      chk("vec_busy", int'(busy), int'(vt[i].e_busy));
      chk("vec_tx", int'(tx), int'(vt[i].e_tx));
    end

    // Idle after reset: line stays high, nothing queued.
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      if (!tx || busy || !empty || level != 0) lows++;
    end
    chk("idle_quiet", lows, 0);

    // Single 0x55 frame: bit pattern and busy length.
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b1, 8'h55, 1'b0);
    n = 0;
    for (int i = 1; i < 400; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      txs[i] = tx;
      if (busy) n++;
    end
    chk("lat_tx_n1", int'(txs[1]), 1);
    chk("lat_tx_n2", int'(txs[2]), 0);
    chk("busy_len", n, FCYC);
    for (int k = 0; k < FRAME; k++) begin
      b = (FRAME == 11 && k == 9) ? 0 : (k == FRAME - 1) ? 1 : (k % 2);
      chk("frame55_bit", int'(txs[2 + 16 * k + 8]), b);
    end

    // Three consecutive pushes: level peaks at 2, frames drain in order.
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 8'h41 + 8'(i), 1'b0);
      if (int'(level) > peak) peak = int'(level);
    end
    for (int i = 0; i < 3 * (FCYC + 1) + 20; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      if (int'(level) > peak) peak = int'(level);
    end
    chk("burst3_peak", peak, 2);
    chk("burst3_drained", int'(empty && !busy), 1);

    // Fill to full while a frame is on the wire, overflow, clear, drain.
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b1, 8'h10, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) tick(1'b0, 1'b1, 8'h20 + 8'(i), 1'b0);
    chk("fill_level", int'(level), 16);
    chk("fill_full", int'(full), 1);
    chk("fill_overflow", int'(overflow), 1);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_overflow", int'(overflow), 0);
    idle(17 * (FCYC + 1) + 50);
    chk("fill_drained", int'(empty && !busy), 1);

    // Reset in the middle of data bit 3 with five bytes queued.
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
    idle(68);
    chk("abort_level_before", int'(level), 5);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("abort_tx", int'(tx), 1);
    chk("abort_level", int'(level), 0);
    chk("abort_busy", int'(busy), 0);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      if (!tx || busy) lows++;
    end
    chk("abort_silent", lows, 0);

`ifdef UART_TX_PARITY_EN
    // Parity bit of 0x07 is 1, of 0x03 is 0.
    tick(1'b0, 1'b1, 8'h07, 1'b0);
    for (int i = 1; i < 400; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      txs[i] = tx;
    end
    chk("parity_07", int'(txs[2 + 16 * 9 + 8]), 1);
    tick(1'b0, 1'b1, 8'h03, 1'b0);
    for (int i = 1; i < 400; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      txs[i] = tx;
    end
    chk("parity_03", int'(txs[2 + 16 * 9 + 8]), 0);
`endif

    // Randomised traffic against the model, with bursts that overrun the FIFO.
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    begin
      int burst;
      int pct;
      burst = 0;
      for (int i = 0; i < 2500; i++) begin
        if (i % 400 == 0) burst = $urandom_range(0, 2);
        pct = (burst == 0) ? 3 : (burst == 1) ? 20 : 60;
        tick(($urandom_range(0, 999) == 0),
             ($urandom_range(0, 99) < pct),
             8'($urandom),
             ($urandom_range(0, 49) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
